// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with 7-bit address match, rx/tx byte streams and SCL stretching.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic       enable,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       rx_ready,
  output logic       tx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;
  typedef struct packed {
    logic [2:0] cnt;
    logic [7:0] shift;
    logic [7:0] tx_shift;
    logic       rw;
    logic       ack;
    logic       first_arm;
    logic       scl_oen;
    logic       sda_oen;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       tx_ready;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       nack_det;
  } regs_t;
  state_t                 r_state, w_state_nxt;
  regs_t                  r_q, w_d;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_rx_free;
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_rx_free  = ~r_q.rx_valid | rx_ready;
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state       <= IDLE;
      r_q           <= '0;
      r_q.scl_oen   <= 1'b1;
      r_q.sda_oen   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_d;
    end
  end
  always_comb begin
    w_state_nxt   = r_state;
    w_d           = r_q;
    w_d.start_det = 1'b0;
    w_d.stop_det  = 1'b0;
    w_d.nack_det  = 1'b0;
    if (r_q.rx_valid && rx_ready) w_d.rx_valid = 1'b0;
    if (!enable || w_stop) begin
      w_state_nxt  = IDLE;
      w_d.stop_det = enable & w_stop;
      w_d.scl_oen  = 1'b1;
      w_d.sda_oen  = 1'b1;
      w_d.tx_ready = 1'b0;
      w_d.busy     = 1'b0;
      w_d.ack      = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_d.start_det = 1'b1;
      w_d.cnt       = '0;
      w_d.scl_oen   = 1'b1;
      w_d.sda_oen   = 1'b1;
      w_d.tx_ready  = 1'b0;
      w_d.ack       = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_scl_rise) begin
          w_d.shift = {r_q.shift[6:0], w_sda};
          w_d.cnt   = r_q.cnt + 3'd1;
          if (r_q.cnt == 3'd7) begin
            w_state_nxt = (r_q.shift[6:0] == TARGET_ADDR) ? ADDR_ACK : IDLE;
            w_d.busy    = 1'b0;
            w_d.rw      = w_sda;
          end
        end
        ADDR_ACK: if (w_scl_fall) begin
          w_d.ack     = ~r_q.ack;
          w_d.sda_oen = r_q.ack;
          w_d.busy    = 1'b1;
          w_d.cnt     = '0;
          if (r_q.ack) begin
            w_state_nxt   = r_q.rw ? TX_LOAD : RX_BYTE;
            w_d.first_arm = ~r_q.rw;
            w_d.scl_oen   = ~r_q.rw;
            w_d.tx_ready  = r_q.rw;
          end
        end
        RX_BYTE: if (w_scl_rise) begin
          w_d.shift = {r_q.shift[6:0], w_sda};
          w_d.cnt   = r_q.cnt + 3'd1;
          if (r_q.cnt == 3'd7) w_state_nxt = RX_ACK;
        end
        RX_ACK: begin
          // a full buffer holds SCL low; the byte lands the cycle the consumer frees it
          if (!r_q.ack && (w_scl_fall || !r_q.scl_oen)) begin
            w_d.scl_oen = ~w_rx_free ? 1'b0 : 1'b1;
            if (w_rx_free) begin
              w_d.rx_data   = r_q.shift;
              w_d.rx_valid  = 1'b1;
              w_d.rx_first  = r_q.first_arm;
              w_d.first_arm = 1'b0;
              w_d.sda_oen   = 1'b0;
              w_d.ack       = 1'b1;
            end
          end else if (r_q.ack && w_scl_fall) begin
            w_state_nxt = RX_BYTE;
            w_d.ack     = 1'b0;
            w_d.sda_oen = 1'b1;
            w_d.cnt     = '0;
          end
        end
        TX_LOAD: if (tx_valid && r_q.tx_ready) begin
          w_state_nxt  = TX_BYTE;
          w_d.tx_shift = tx_data;
          w_d.sda_oen  = tx_data[7];
          w_d.scl_oen  = 1'b1;
          w_d.tx_ready = 1'b0;
          w_d.cnt      = '0;
        end
        TX_BYTE: if (w_scl_fall) begin
          w_d.cnt      = r_q.cnt + 3'd1;
          w_d.tx_shift = {r_q.tx_shift[6:0], 1'b1};
          w_d.sda_oen  = (r_q.cnt == 3'd7) ? 1'b1 : r_q.tx_shift[6];
          if (r_q.cnt == 3'd7) w_state_nxt = TX_ACK;
        end
        TX_ACK: begin
          if (!r_q.ack && w_scl_rise) begin
            w_d.ack      = ~w_sda;
            w_d.nack_det = w_sda;
            if (w_sda) w_state_nxt = WAIT_STOP;
          end else if (r_q.ack && w_scl_fall) begin
            w_state_nxt  = TX_LOAD;
            w_d.ack      = 1'b0;
            w_d.scl_oen  = 1'b0;
            w_d.tx_ready = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen   = r_q.scl_oen;
  assign sda_oen   = r_q.sda_oen;
  assign rx_valid  = r_q.rx_valid;
  assign rx_data   = r_q.rx_data;
  assign rx_first  = r_q.rx_first;
  assign tx_ready  = r_q.tx_ready;
  assign start_det = r_q.start_det;
  assign stop_det  = r_q.stop_det;
  assign nack_det  = r_q.nack_det;
  assign busy      = r_q.busy;
endmodule
